// File: rtl/input_conditioner.sv
// Per-channel input conditioning: synchroniser chain, stability-count debouncer and
// registered rise/fall pulse generation for raw board switches and pushbuttons.
module input_conditioner #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  clean_q, clean_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0]                  s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // Any sample agreeing with the accepted level restarts the stability count.
            if (s[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                clean_d[i] = s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed vector table plus randomized traffic against a
// window-based reference model, on a default instance and a DEBOUNCE_CYCLES=1 instance.
module tb_input_conditioner;

    localparam int W  = 3;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw_in = 3'b111;
    logic [W-1:0] clean4, rise4, fall4;
    logic [W-1:0] clean1, rise1, fall1;

    always #5 clk = ~clk;

    input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .clean(clean4), .rise(rise4), .fall(fall4)
    );

    input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .clean(clean1), .rise(rise1), .fall(fall1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a level is accepted once the last D synchronised samples taken
    // since the previous acceptance all disagree with the current level.
    logic [W-1:0] m_clean [2];
    logic [W-1:0] m_rise  [2];
    logic [W-1:0] m_fall  [2];
    int           m_len   [2][W];
    logic [31:0]  m_mis   [2][W];
    logic [W-1:0] pipe [$];
    int           dcyc [2] = '{4, 1};

    task automatic model_reset();
        pipe = {};
        for (int k = 0; k < SS; k++) pipe.push_back('0);
        for (int n = 0; n < 2; n++) begin
            m_clean[n] = '0;
            m_rise[n]  = '0;
            m_fall[n]  = '0;
            for (int c = 0; c < W; c++) begin
                m_len[n][c] = 0;
                m_mis[n][c] = '0;
            end
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        logic [31:0]  mask;
        if (rst) begin
            model_reset();
            return;
        end
        s = pipe.pop_front();
        pipe.push_back(raw_in);
        for (int n = 0; n < 2; n++) begin
            mask = (32'd1 << dcyc[n]) - 32'd1;
            m_rise[n] = '0;
            m_fall[n] = '0;
            for (int c = 0; c < W; c++) begin
                m_mis[n][c] = {m_mis[n][c][30:0], s[c] != m_clean[n][c]};
                m_len[n][c]++;
                if (m_len[n][c] >= dcyc[n] && (m_mis[n][c] & mask) == mask) begin
                    m_clean[n][c] = ~m_clean[n][c];
                    if (m_clean[n][c]) m_rise[n][c] = 1'b1;
                    else               m_fall[n][c] = 1'b1;
                    m_len[n][c] = 0;
                    m_mis[n][c] = '0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("clean_d4", clean4, m_clean[0]);
        check("rise_d4",  rise4,  m_rise[0]);
        check("fall_d4",  fall4,  m_fall[0]);
        check("clean_d1", clean1, m_clean[1]);
        check("rise_d1",  rise1,  m_rise[1]);
        check("fall_d1",  fall1,  m_fall[1]);
        check("rise_and_fall_d4", rise4 & fall4, '0);
    endtask

    typedef struct {
        logic         r;
        logic [W-1:0] raw;
        int           n;
        logic [W-1:0] c;
        logic [W-1:0] ri;
        logic [W-1:0] f;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(logic r, logic [W-1:0] raw, int n,
                                logic [W-1:0] c, logic [W-1:0] ri, logic [W-1:0] f);
        vec_t v;
        v.r = r; v.raw = raw; v.n = n; v.c = c; v.ri = ri; v.f = f;
        return v;
    endfunction

    initial begin
        model_reset();

        // Reset held with inputs high, then release and accept 111.
        tbl.push_back(mk(1, 3'b111, 3, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b111, 5, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b111, 1, 3'b111, 3'b111, 3'b000));
        tbl.push_back(mk(0, 3'b111, 1, 3'b111, 3'b000, 3'b000));
        // All channels fall together.
        tbl.push_back(mk(0, 3'b000, 5, 3'b111, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 3'b111));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 3'b000));
        // Single channel rise.
        tbl.push_back(mk(0, 3'b001, 5, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b001, 1, 3'b001, 3'b001, 3'b000));
        tbl.push_back(mk(0, 3'b001, 1, 3'b001, 3'b000, 3'b000));
        // Three-cycle glitch on channel 1 is rejected.
        tbl.push_back(mk(0, 3'b011, 3, 3'b001, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b001, 20, 3'b001, 3'b000, 3'b000));
        // Channel 2 bounces for ten cycles, then settles high.
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, (k % 2 == 0) ? 3'b101 : 3'b001, 1, 3'b001, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b101, 5, 3'b001, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b101, 1, 3'b101, 3'b100, 3'b000));
        tbl.push_back(mk(0, 3'b101, 1, 3'b101, 3'b000, 3'b000));
        // Reset in the middle of a count discards it.
        tbl.push_back(mk(1, 3'b000, 1, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b001, 3, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(1, 3'b001, 1, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b001, 5, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b001, 1, 3'b001, 3'b001, 3'b000));
        tbl.push_back(mk(0, 3'b001, 1, 3'b001, 3'b000, 3'b000));

        foreach (tbl[i]) begin
            rst    = tbl[i].r;
            raw_in = tbl[i].raw;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d_clean", i), clean4, tbl[i].c);
            check($sformatf("vec%0d_rise", i),  rise4,  tbl[i].ri);
            check($sformatf("vec%0d_fall", i),  fall4,  tbl[i].f);
        end

        // Randomized traffic: mixes short bounces, long holds and occasional resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0)
                raw_in = raw_in ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 39) == 0)
                raw_in = W'($urandom_range(0, 7));
            step();
        end

        rst = 1'b0;
        repeat (12) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
